// File: rtl/ptw_mem_port.sv
// PTW memory port: issues one physical PTE load at a time to the data cache,
// with nack/replay re-issue, response timeout and walk-flush handling.

package ptw_mem_port_pkg;
  localparam int SIZE_VADDR = 39;

  typedef logic [63:0] pte_t;

  typedef struct packed {
    logic                  valid;
    logic [SIZE_VADDR:0]   addr;
    logic [4:0]            cmd;
    logic [3:0]            typ;
    logic                  kill;
    logic                  phys;
    logic [63:0]           data;
  } ptw_dmem_req_t;

  typedef struct packed {
    logic        valid;
    logic        nack;
    logic        replay;
    logic        has_data;
    logic [63:0] data;
    logic        xcpt_ma_ld;
    logic        xcpt_pf_ld;
  } dmem_ptw_resp_t;
endpackage

// state | meaning
// IDLE  | ready for a PTW request
// ISSUE | dmem request valid, waiting for dmem_ready_i
// WAIT  | request accepted by dmem, waiting for its response
// DRAIN | walk flushed while a response is owed; swallow it (or its timeout)
// RESP  | registering the one-cycle response to the PTW
module ptw_mem_port
  import ptw_mem_port_pkg::*;
#(
  parameter int MAX_RETRIES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                req_valid_i,
  input  logic [SIZE_VADDR:0] req_addr_i,
  output logic                req_ready_o,
  input  logic                flush_i,
  output logic                resp_valid_o,
  output pte_t                resp_pte_o,
  output logic                resp_error_o,
  input  logic                dmem_ready_i,
  output ptw_dmem_req_t       dmem_req_o,
  input  dmem_ptw_resp_t      dmem_resp_i
);

  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SIZE_VADDR:0] r_addr;
  logic [RW-1:0]       r_retry;
  logic [TW-1:0]       r_tmo;
  logic                r_err;
  pte_t                r_pte;
  logic                r_resp_valid;
  logic                r_resp_err;

  logic                w_dmem_valid;
  logic                w_accept;
  logic                w_ld_data;
  logic                w_set_err;
  logic                w_err_val;
  logic                w_retry_inc;
  logic                w_tmo_clr;
  logic                w_tmo_inc;
  logic                w_resp_fire;
  logic [RW-1:0]       w_retry_new;
  logic [TW-1:0]       w_tmo_new;
  logic                w_retry_exh;
  logic                w_tmo_exp;
  logic                w_nack;

  // Saturating next values of both counters; neither may wrap.
  assign w_retry_new = (&r_retry) ? r_retry : r_retry + RW'(1);
  assign w_tmo_new   = (&r_tmo)   ? r_tmo   : r_tmo + TW'(1);
  assign w_retry_exh = (w_retry_new > RW'(MAX_RETRIES));
  assign w_tmo_exp   = (w_tmo_new >= TW'(TIMEOUT_CYCLES));
  assign w_nack      = dmem_resp_i.nack | dmem_resp_i.replay;

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic and per-state control strobes.
  always_comb begin
    w_state_nxt  = r_state;
    req_ready_o  = 1'b0;
    w_dmem_valid = 1'b0;
    w_accept     = 1'b0;
    w_ld_data    = 1'b0;
    w_set_err    = 1'b0;
    w_err_val    = 1'b0;
    w_retry_inc  = 1'b0;
    w_tmo_clr    = 1'b0;
    w_tmo_inc    = 1'b0;
    w_resp_fire  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i && !flush_i) begin
          w_accept = 1'b1;
          if (|req_addr_i[2:0]) begin
            w_set_err   = 1'b1;
            w_err_val   = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Valid is gated by flush so dmem can never accept an abandoned request.
        if (flush_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_dmem_valid = 1'b1;
          if (dmem_ready_i) begin
            w_tmo_clr   = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_resp_i.valid) begin
          if (flush_i) begin
            // The owed response is here already, nothing left to drain.
            w_state_nxt = S_IDLE;
          end else if (w_nack) begin
            w_retry_inc = 1'b1;
            if (w_retry_exh) begin
              w_set_err   = 1'b1;
              w_err_val   = 1'b1;
              w_state_nxt = S_RESP;
            end else begin
              w_state_nxt = S_ISSUE;
            end
          end else if (dmem_resp_i.has_data) begin
            w_ld_data   = 1'b1;
            w_set_err   = 1'b1;
            w_err_val   = dmem_resp_i.xcpt_pf_ld | dmem_resp_i.xcpt_ma_ld;
            w_state_nxt = S_RESP;
          end
        end else if (flush_i) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_tmo_inc = 1'b1;
          if (w_tmo_exp) begin
            w_set_err   = 1'b1;
            w_err_val   = 1'b1;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_DRAIN: begin
        if (dmem_resp_i.valid) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_inc = 1'b1;
          if (w_tmo_exp) w_state_nxt = S_IDLE;
        end
      end
      S_RESP: begin
        w_resp_fire = !flush_i;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, counters, PTE data and the registered response outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_addr       <= '0;
      r_retry      <= '0;
      r_tmo        <= '0;
      r_err        <= 1'b0;
      r_pte        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_resp_fire;
      r_resp_err   <= w_resp_fire & r_err;
      if (w_accept) begin
        r_addr  <= req_addr_i;
        r_retry <= '0;
        r_pte   <= '0;
      end
      if (w_set_err)        r_err <= w_err_val;
      else if (w_accept)    r_err <= 1'b0;
      if (w_retry_inc)      r_retry <= w_retry_new;
      // The timeout window restarts at every dmem handshake.
      if (w_accept || w_tmo_clr) r_tmo <= '0;
      else if (w_tmo_inc)        r_tmo <= w_tmo_new;
      if (w_ld_data)        r_pte <= dmem_resp_i.data;
    end
  end

  // Fixed-format physical doubleword load.
  always_comb begin
    dmem_req_o       = '0;
    dmem_req_o.valid = w_dmem_valid;
    dmem_req_o.addr  = r_addr;
    dmem_req_o.cmd   = 5'b00000;
    dmem_req_o.typ   = 4'b0011;
    dmem_req_o.kill  = 1'b0;
    dmem_req_o.phys  = 1'b1;
    dmem_req_o.data  = '0;
  end

  assign resp_valid_o = r_resp_valid;
  assign resp_error_o = r_resp_err;
  assign resp_pte_o   = r_pte;

endmodule

// File: tb/tb_ptw_mem_port.sv
// Transaction-level bench for ptw_mem_port: directed vector table, random
// transactions against an outcome model, and hand-written flush/reset/timeout sequences.
module tb_ptw_mem_port;
  import ptw_mem_port_pkg::*;

  localparam int MAXR = 4;
  localparam int TMO  = 64;

  logic           clk;
  logic           rstn;
  logic           req_valid;
  logic [39:0]    req_addr;
  logic           req_ready;
  logic           flush;
  logic           resp_valid;
  pte_t           resp_pte;
  logic           resp_error;
  logic           dmem_ready;
  ptw_dmem_req_t  dmem_req;
  dmem_ptw_resp_t dmem_resp;

  ptw_mem_port #(.MAX_RETRIES(MAXR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .req_ready_o  (req_ready),
    .flush_i      (flush),
    .resp_valid_o (resp_valid),
    .resp_pte_o   (resp_pte),
    .resp_error_o (resp_error),
    .dmem_ready_i (dmem_ready),
    .dmem_req_o   (dmem_req),
    .dmem_resp_i  (dmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] addr;
    int          rdly;
    int          lat;
    int          nnack;
    bit          tmo;
    logic [63:0] data;
    bit          pf;
    bit          ma;
    int          exp_iss;
    bit          exp_err;
    bit          chk_pte;
  } vec_t;

  vec_t tbl[8];
  int   n_chk  = 0;
  int   n_fail = 0;

  int   mon_iss  = 0;
  int   mon_vld  = 0;
  int   mon_resp = 0;
  bit   mon_err  = 1'b0;
  pte_t mon_pte  = '0;

  // Observe handshakes and response pulses mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (dmem_req.valid) mon_vld++;
      if (dmem_req.valid && dmem_ready) mon_iss++;
      if (resp_valid) begin
        mon_resp++;
        mon_err = resp_error;
        mon_pte = resp_pte;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outcome of one walk read, from the request/dmem behaviour alone.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    if (v.addr[2:0] != 3'd0) begin
      r.exp_iss = 0; r.exp_err = 1'b1; r.chk_pte = 1'b0;
    end else if (v.nnack > MAXR) begin
      r.exp_iss = MAXR + 1; r.exp_err = 1'b1; r.chk_pte = 1'b0;
    end else if (v.tmo) begin
      r.exp_iss = v.nnack + 1; r.exp_err = 1'b1; r.chk_pte = 1'b0;
    end else begin
      r.exp_iss = v.nnack + 1; r.exp_err = v.pf | v.ma; r.chk_pte = !(v.pf | v.ma);
    end
    return r;
  endfunction

  task automatic send_req(input logic [39:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  // Play the data cache for one request: ready delay, nacks, final response.
  task automatic dmem_serve(input vec_t v);
    int nissue;
    int n;
    nissue = (v.nnack > MAXR) ? MAXR + 1 : v.nnack + 1;
    for (int k = 0; k < nissue; k++) begin
      n = 0;
      while (!dmem_req.valid && n < 50) begin
        step();
        n++;
      end
      chk("issue_seen", 64'(n < 50), 64'd1);
      if (n >= 50) return;
      repeat (v.rdly) step();
      chk("req_addr", dmem_req.addr, v.addr);
      chk("req_fields", {dmem_req.cmd, dmem_req.typ, dmem_req.phys, dmem_req.kill},
          {5'b00000, 4'b0011, 1'b1, 1'b0});
      dmem_ready = 1'b1;
      step();
      dmem_ready = 1'b0;
      if (k < v.nnack) begin
        repeat (v.lat) step();
        dmem_resp = '0;
        dmem_resp.valid = 1'b1;
        if ($urandom_range(0, 1) == 0) dmem_resp.nack = 1'b1;
        else dmem_resp.replay = 1'b1;
        dmem_resp.has_data = 1'($urandom_range(0, 1));
        dmem_resp.data = {$urandom, $urandom};
        step();
        dmem_resp = '0;
      end else if (!v.tmo) begin
        repeat (v.lat) step();
        dmem_resp = '0;
        dmem_resp.valid = 1'b1;
        dmem_resp.has_data = 1'b1;
        dmem_resp.data = v.data;
        dmem_resp.xcpt_pf_ld = v.pf;
        dmem_resp.xcpt_ma_ld = v.ma;
        step();
        dmem_resp = '0;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int b_iss, b_resp, b_vld, n;
    b_iss = mon_iss; b_resp = mon_resp; b_vld = mon_vld;
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    send_req(v.addr);
    if (v.addr[2:0] == 3'd0) dmem_serve(v);
    n = 0;
    while (mon_resp == b_resp && n < 200) begin
      step();
      n++;
    end
    repeat (3) step();
    chk({tag, "_resp_cnt"}, 64'(mon_resp - b_resp), 64'd1);
    chk({tag, "_issues"}, 64'(mon_iss - b_iss), 64'(v.exp_iss));
    chk({tag, "_err"}, 64'(mon_err), 64'(v.exp_err));
    if (v.chk_pte) chk({tag, "_pte"}, mon_pte, v.data);
    if (v.exp_iss == 0) chk({tag, "_no_dmem_valid"}, 64'(mon_vld - b_vld), 64'd0);
  endtask

  initial begin
    vec_t v;
    int   b_resp, b_vld, n;
    rstn = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    dmem_ready = 1'b0; dmem_resp = '0;

    //          addr            rdly lat nnack tmo data                   pf ma  iss err pte
    tbl[0] = '{40'h0080001008, 2, 3, 0, 1'b0, 64'h0000_0000_2000_00CF, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    tbl[1] = '{40'h0080001004, 0, 0, 0, 1'b0, 64'h0,                   1'b0, 1'b0, 0, 1'b1, 1'b0};
    tbl[2] = '{40'h0080002000, 0, 1, 5, 1'b0, 64'h1111,                1'b0, 1'b0, 5, 1'b1, 1'b0};
    tbl[3] = '{40'h0080002008, 1, 2, 4, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 5, 1'b0, 1'b1};
    tbl[4] = '{40'h0080003010, 0, 0, 0, 1'b0, 64'h5555,                1'b1, 1'b0, 1, 1'b1, 1'b0};
    tbl[5] = '{40'h0080003018, 3, 4, 1, 1'b0, 64'h7777,                1'b0, 1'b1, 2, 1'b1, 1'b0};
    tbl[6] = '{40'h0080004020, 0, 1, 2, 1'b1, 64'h0,                   1'b0, 1'b0, 3, 1'b1, 1'b0};
    tbl[7] = '{40'h00FFFFFFF8, 0, 0, 1, 1'b0, 64'h8000_0000_0000_00FF, 1'b0, 1'b0, 2, 1'b0, 1'b1};

    // Reset state
    #12;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_error), 64'd0);
    chk("rst_pte", resp_pte, 64'd0);
    chk("rst_dmem_req", 64'(dmem_req.valid), 64'd0);
    chk("rst_dmem_addr", 64'(dmem_req.addr), 64'd0);
    chk("rst_dmem_ctl", {dmem_req.cmd, dmem_req.typ, dmem_req.kill, dmem_req.phys},
        {5'b00000, 4'b0011, 1'b0, 1'b1});
    step();
    rstn = 1'b1;
    step();

    // Directed vector table
    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Misaligned: response is registered two edges after the accepting edge
    b_vld = mon_vld;
    send_req(40'h0080001004);
    @(negedge clk); chk("mis_lat_e1", 64'(resp_valid), 64'd0);
    @(negedge clk); chk("mis_lat_e2", 64'(resp_valid), 64'd1);
    chk("mis_lat_err", 64'(resp_error), 64'd1);
    @(negedge clk); chk("mis_lat_e3", 64'(resp_valid), 64'd0);
    chk("mis_lat_no_valid", 64'(mon_vld - b_vld), 64'd0);
    step();

    // Timeout: 64 WAIT cycles, one RESP cycle, then the registered pulse
    v = model('{40'h0080005000, 0, 0, 0, 1'b1, 64'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0});
    send_req(v.addr);
    dmem_serve(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 100);
    chk("tmo_latency", 64'(n), 64'd66);
    chk("tmo_err", 64'(resp_error), 64'd1);
    step();
    b_resp = mon_resp;
    dmem_resp = '0; dmem_resp.valid = 1'b1; dmem_resp.has_data = 1'b1; dmem_resp.data = 64'hBAD;
    step();
    dmem_resp = '0;
    repeat (3) step();
    chk("late_resp_ignored", 64'(mon_resp - b_resp), 64'd0);
    chk("late_resp_ready", 64'(req_ready), 64'd1);

    // Flush in WAIT, response two cycles later is swallowed
    b_resp = mon_resp;
    send_req(40'h0080006000);
    dmem_ready = 1'b1; step(); dmem_ready = 1'b0;
    step();
    flush = 1'b1; step(); flush = 1'b0;
    step(); step();
    dmem_resp = '0; dmem_resp.valid = 1'b1; dmem_resp.has_data = 1'b1; dmem_resp.data = 64'h123;
    chk("drain_not_ready", 64'(req_ready), 64'd0);
    step();
    dmem_resp = '0;
    chk("drain_ready_after", 64'(req_ready), 64'd1);
    repeat (3) step();
    chk("drain_no_resp", 64'(mon_resp - b_resp), 64'd0);

    // Flush in ISSUE drops valid combinationally, back to IDLE
    b_resp = mon_resp;
    send_req(40'h0080006008);
    chk("iss_valid", 64'(dmem_req.valid), 64'd1);
    flush = 1'b1; dmem_ready = 1'b1;
    #1;
    chk("iss_flush_drop", 64'(dmem_req.valid), 64'd0);
    step();
    flush = 1'b0; dmem_ready = 1'b0;
    chk("iss_flush_idle", 64'(req_ready), 64'd1);
    repeat (3) step();
    chk("iss_flush_no_resp", 64'(mon_resp - b_resp), 64'd0);

    // Flush in RESP suppresses the pulse
    b_resp = mon_resp;
    v = model('{40'h0080007000, 0, 1, 0, 1'b0, 64'hABCD, 1'b0, 1'b0, 0, 1'b0, 1'b0});
    send_req(v.addr);
    dmem_serve(v);
    flush = 1'b1; step(); flush = 1'b0;
    repeat (3) step();
    chk("resp_flush_no_resp", 64'(mon_resp - b_resp), 64'd0);
    chk("resp_flush_ready", 64'(req_ready), 64'd1);

    // Reset while issuing: immediate IDLE, no response, then normal service
    b_resp = mon_resp;
    send_req(40'h0080008000);
    chk("rst_mid_valid_before", 64'(dmem_req.valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(dmem_req.valid), 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd1);
    step(); step();
    rstn = 1'b1;
    repeat (3) step();
    chk("rst_mid_no_resp", 64'(mon_resp - b_resp), 64'd0);
    run_vec(tbl[0], "post_rst");

    // Random transactions against the outcome model
    for (int i = 0; i < 40; i++) begin
      v.addr  = {$urandom, $urandom};
      v.addr[2:0] = ($urandom_range(0, 99) < 15) ? 3'(1 + $urandom_range(0, 6)) : 3'd0;
      v.rdly  = $urandom_range(0, 3);
      v.lat   = $urandom_range(0, 5);
      v.nnack = $urandom_range(0, 6);
      v.tmo   = ($urandom_range(0, 99) < 10);
      v.data  = {$urandom, $urandom};
      v.pf    = ($urandom_range(0, 99) < 10);
      v.ma    = ($urandom_range(0, 99) < 10);
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
